// File: rtl/lfsr16_pkg.sv
// Shared 16-bit LFSR definitions: tap mask, step function and checker FSM states.
// The generator and the checker both use lfsr16_step, so the taps live in one place.
package lfsr16_pkg;

    localparam logic [15:0] LFSR16_TAP_MASK = 16'h8004;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_chk_state_t;

    // Rotate left by one, then fold the outgoing MSB into the tap positions.
    function automatic logic [15:0] lfsr16_step(input logic [15:0] x);
        return {x[14:0], x[15]} ^ (x[15] ? LFSR16_TAP_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/prbs16_checker.sv
// Receive-side PRBS16 checker: self-synchronises to the LFSR sequence, then
// free-runs its prediction and reports whole-word mismatches while locked.
module prbs16_checker
    import lfsr16_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic [15:0]      data_in,
    input  logic             clear_in,
    output logic             locked_out,
    output logic             err_out,
    output logic [ERR_W-1:0] err_count_out
);

    localparam int RUN_W  = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);

    prbs_chk_state_t   state;
    logic [15:0]       expect_q;
    logic [RUN_W-1:0]  run;
    logic [MISS_W-1:0] miss;

    logic word_match;
    logic word_zero;

    assign word_match = (data_in == expect_q);
    assign word_zero  = (data_in == 16'h0000);
    assign locked_out = (state == LOCKED);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state         <= SEARCH;
            expect_q      <= '0;
            run           <= '0;
            miss          <= '0;
            err_out       <= 1'b0;
            err_count_out <= '0;
        end else begin
            err_out <= 1'b0;
            if (valid_in) begin
                case (state)
                    SEARCH: begin
                        if (!word_zero) begin
                            expect_q <= lfsr16_step(data_in);
                            run      <= '0;
                            state    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (word_match) begin
                            expect_q <= lfsr16_step(data_in);
                            run      <= run + RUN_W'(1);
                            if (run == RUN_LAST) begin
                                state <= LOCKED;
                                miss  <= '0;
                            end
                        end else if (!word_zero) begin
                            expect_q <= lfsr16_step(data_in);
                            run      <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        // Prediction free-runs; received data never reseeds it here.
                        expect_q <= lfsr16_step(expect_q);
                        if (word_match) begin
                            miss <= '0;
                        end else begin
                            err_out <= 1'b1;
                            if (err_count_out != '1)
                                err_count_out <= err_count_out + ERR_W'(1);
                            miss <= miss + MISS_W'(1);
                            if (miss == MISS_LAST) begin
                                state <= SEARCH;
                                run   <= '0;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            // Later assignment overrides a same-cycle increment.
            if (clear_in)
                err_count_out <= '0;
        end
    end

endmodule

// File: tb/tb_prbs16_checker.sv
// Scoreboarded bench for prbs16_checker: two instances (default and ERR_W=4 with a
// large LOSS_COUNT) share one stimulus stream and are checked against a reference model.
module tb_prbs16_checker;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [15:0] data_in = '0;

    logic        locked_a, err_a;
    logic [15:0] cnt_a;
    logic        locked_b, err_b;
    logic [3:0]  cnt_b;

    always #5 clk_in = ~clk_in;

    prbs16_checker dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .data_in(data_in),
        .clear_in(clear_in), .locked_out(locked_a), .err_out(err_a), .err_count_out(cnt_a)
    );

    prbs16_checker #(.LOCK_COUNT(4), .LOSS_COUNT(1000), .ERR_W(4)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .data_in(data_in),
        .clear_in(clear_in), .locked_out(locked_b), .err_out(err_b), .err_count_out(cnt_b)
    );

    // st: 0 = hunting for a nonzero seed, 1 = confirming, 2 = locked
    typedef struct {
        int          st;
        logic [15:0] exp;
        int          run;
        int          miss;
        int          cnt;
        bit          err;
    } mdl_t;

    typedef struct {
        bit locked;
        bit err;
        int cnt;
    } obs_t;

    mdl_t        ma, mb;
    obs_t        qa[$];
    obs_t        qb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] g;

    // Next LFSR word from plain arithmetic: shift left with wrap, then apply taps.
    function automatic logic [15:0] nxt(input logic [15:0] x);
        int v;
        int r;
        v = int'(x);
        r = ((v * 2) % 65536) + (v / 32768);
        if (v >= 32768) r = r ^ 32'h8004;
        return r[15:0];
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int lockc, input int lossc,
                                   input int cmax, input bit r, input bit v,
                                   input logic [15:0] d, input bit c);
        mdl_t o;
        bit   bad;
        o = m;
        o.err = 1'b0;
        if (!r) begin
            o = '{0, 16'h0000, 0, 0, 0, 1'b0};
            return o;
        end
        if (v) begin
            if (o.st == 0) begin
                if (d != 16'h0000) begin
                    o.exp = nxt(d);
                    o.run = 0;
                    o.st  = 1;
                end
            end else if (o.st == 1) begin
                if (d == o.exp) begin
                    o.exp = nxt(d);
                    o.run = o.run + 1;
                    if (o.run == lockc) begin
                        o.st   = 2;
                        o.miss = 0;
                    end
                end else if (d != 16'h0000) begin
                    o.exp = nxt(d);
                    o.run = 0;
                end else begin
                    o.st = 0;
                end
            end else begin
                bad   = (d != o.exp);
                o.exp = nxt(o.exp);
                if (!bad) begin
                    o.miss = 0;
                end else begin
                    o.err  = 1'b1;
                    if (o.cnt < cmax) o.cnt = o.cnt + 1;
                    o.miss = o.miss + 1;
                    if (o.miss == lossc) begin
                        o.st  = 0;
                        o.run = 0;
                    end
                end
            end
        end
        if (c) o.cnt = 0;
        return o;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [15:0] d, input bit c);
        @(negedge clk_in);
        rst_in   = r;
        valid_in = v;
        data_in  = d;
        clear_in = c;
        ma = mstep(ma, 4, 3, 65535, r, v, d, c);
        mb = mstep(mb, 4, 1000, 15, r, v, d, c);
        qa.push_back('{(ma.st == 2), ma.err, ma.cnt});
        qb.push_back('{(mb.st == 2), mb.err, mb.cnt});
    endtask

    task automatic good_word();
        drive(1'b1, 1'b1, g, 1'b0);
        g = nxt(g);
    endtask

    task automatic settle();
        @(posedge clk_in);
        #2;
    endtask

    // Monitor: one expected entry per sampled edge, compared just after the edge.
    always @(posedge clk_in) begin
        obs_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("a.locked", int'(locked_a), int'(e.locked));
            check("a.err",    int'(err_a),    int'(e.err));
            check("a.count",  int'(cnt_a),    e.cnt);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("b.locked", int'(locked_b), int'(e.locked));
            check("b.err",    int'(err_b),    int'(e.err));
            check("b.count",  int'(cnt_b),    e.cnt);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit          r, v, c;
        logic [15:0] d;
        ma = '{0, 16'h0000, 0, 0, 0, 1'b0};
        mb = ma;

        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b1, 16'h5555, 1'b1);
        settle();
        check("reset.locked_a", int'(locked_a), 0);
        check("reset.count_a",  int'(cnt_a), 0);

        // Clean stream from the reference seed
        g = 16'hACE1;
        for (int i = 0; i < 1000; i++) good_word();
        settle();
        check("stream.locked_a", int'(locked_a), 1);
        check("stream.count_a",  int'(cnt_a), 0);

        // Single bit-0 flip while locked
        drive(1'b1, 1'b1, g ^ 16'h0001, 1'b0);
        g = nxt(g);
        for (int i = 0; i < 10; i++) good_word();
        settle();
        check("flip.count_a",  int'(cnt_a), 1);
        check("flip.locked_a", int'(locked_a), 1);

        // Three substituted words drop lock on the default instance only
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'h1234, 1'b0);
            g = nxt(g);
        end
        settle();
        check("loss.locked_a", int'(locked_a), 0);
        check("loss.count_a",  int'(cnt_a), 4);
        check("loss.locked_b", int'(locked_b), 1);
        for (int i = 0; i < 5; i++) good_word();
        settle();
        check("relock.locked_a", int'(locked_a), 1);

        // All-zero words never seed; a zero during confirmation returns to search
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 16'h0000, 1'b0);
        settle();
        check("zeros.locked_a", int'(locked_a), 0);
        good_word();
        good_word();
        drive(1'b1, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) good_word();
        settle();
        check("zero_in_verify.locked_a", int'(locked_a), 0);
        for (int i = 0; i < 4; i++) good_word();

        // Valid pattern 1/0/0/1 with noise on idle cycles
        for (int i = 0; i < 200; i++) begin
            if ((i % 4 == 0) || (i % 4 == 3)) good_word();
            else drive(1'b1, 1'b0, 16'($urandom), 1'b0);
        end
        settle();
        check("gaps.locked_a", int'(locked_a), 1);

        // Saturation on the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, g ^ 16'h00FF, 1'b0);
            g = nxt(g);
        end
        settle();
        check("sat.count_b",  int'(cnt_b), 15);
        check("sat.locked_b", int'(locked_b), 1);
        for (int i = 0; i < 6; i++) good_word();
        drive(1'b1, 1'b1, g ^ 16'h0001, 1'b1);
        g = nxt(g);
        settle();
        check("clear_vs_err.count_b", int'(cnt_b), 0);
        check("clear_vs_err.err_b",   int'(err_b), 1);
        for (int i = 0; i < 3; i++) good_word();
        drive(1'b0, 1'b1, g, 1'b0);
        g = nxt(g);
        settle();
        check("midreset.locked_b", int'(locked_b), 0);
        check("midreset.count_b",  int'(cnt_b), 0);
        check("midreset.locked_a", int'(locked_a), 0);

        // Randomised phase
        g = 16'($urandom_range(1, 65535));
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 299) != 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            d = g;
            if ($urandom_range(0, 19) == 0) d = g ^ 16'($urandom_range(1, 65535));
            else if ($urandom_range(0, 99) == 0) d = 16'h0000;
            if (!v) d = 16'($urandom);
            drive(r, v, d, c);
            if (v) g = nxt(g);
        end

        repeat (3) @(posedge clk_in);
        #2;
        check("queue_drain", qa.size() + qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
